// File: rtl/icache_l1_pkg.sv
// Shared sizes, address field slicing and FSM state encoding for the L1 instruction cache.
package icache_l1_pkg;

  localparam int PA_W    = 34;
  localparam int LINE_W  = 256;
  localparam int SETS    = 128;
  localparam int TAG_W   = 22;
  localparam int WAYS    = 2;
  localparam int OFF_W   = 5;
  localparam int IDX_W   = 7;
  localparam int IDX_LSB = OFF_W;
  localparam int TAG_LSB = OFF_W + IDX_W;

  typedef logic [PA_W-1:0]   pa_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL_WAIT,
    RESP
  } state_t;

  function automatic idx_t pa_index(input pa_t pa);
    return pa[IDX_LSB +: IDX_W];
  endfunction

  function automatic tag_t pa_tag(input pa_t pa);
    return pa[TAG_LSB +: TAG_W];
  endfunction

  // Byte offset is dropped: L2 always works on whole lines.
  function automatic pa_t line_addr(input pa_t pa);
    return {pa[PA_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_l1_array.sv
// Two-way tag/valid/data storage with one LRU bit per set; combinational read,
// single write port and victim selection for the set currently being read.
module icache_l1_array
  import icache_l1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [1:0]        rd_valid,
  output logic [TAG_W-1:0]  rd_tag0,
  output logic [TAG_W-1:0]  rd_tag1,
  output logic [LINE_W-1:0] rd_data0,
  output logic [LINE_W-1:0] rd_data1,
  output logic              victim_way,
  input  logic              wr_en,
  input  logic              wr_way,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              lru_we,
  input  logic [IDX_W-1:0]  lru_index,
  input  logic              lru_used_way
);

  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];

  // NOTE: only valid and LRU bits are reset; tag/data contents are meaningless
  // while invalid, and leaving them unreset keeps them plain RAM-style storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (wr_en) begin
        valid_q[wr_way][wr_index] <= 1'b1;
      end
      if (lru_we) begin
        lru_q[lru_index] <= ~lru_used_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way][wr_index]  <= wr_tag;
      data_q[wr_way][wr_index] <= wr_data;
    end
  end

  assign rd_valid = {valid_q[1][rd_index], valid_q[0][rd_index]};
  assign rd_tag0  = tag_q[0][rd_index];
  assign rd_tag1  = tag_q[1][rd_index];
  assign rd_data0 = data_q[0][rd_index];
  assign rd_data1 = data_q[1][rd_index];

  // Fill an empty way first (way0 preferred), otherwise evict the LRU way.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    victim_way = lru_q[rd_index];
    if (!valid_q[0][rd_index]) begin
      victim_way = 1'b0;
    end else if (!valid_q[1][rd_index]) begin
      victim_way = 1'b1;
    end
  end

endmodule

// File: rtl/icache_l1.sv
// L1 instruction cache top: request/lookup/miss/refill/response control FSM
// around the two-way storage array.
module icache_l1
  import icache_l1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_Itlb_drive,
  input  logic [PA_W-1:0]   i_Itlb_PA_34,
  output logic              o_Itlb_free,
  output logic              o_driveNext_L2Cache,
  output logic [PA_W-1:0]   o_miss_Addr_to_L2cache_34,
  input  logic              i_freeNext_L2Cache,
  output logic              o_L2Cache_free,
  input  logic              i_L2Cache_drive,
  input  logic [LINE_W-1:0] i_L2Cache_refillLine_32B,
  output logic              o_driveNext_ifu,
  output logic [LINE_W-1:0] o_hit_data_to_ifu_32B,
  input  logic              i_freeNext_ifu,
  output logic              o_write_enable,
  output logic [1:0]        o_fifo_buffer_write_enable_2,
  output logic [PA_W-1:0]   o_fifo2_1_addr_34,
  output logic              o_fifo_buffer_data_out
);

  state_t      state_q;
  logic [PA_W-1:0] req_pa_q;

  idx_t        req_index;
  tag_t        req_tag;
  logic [1:0]  rd_valid;
  tag_t        rd_tag0;
  tag_t        rd_tag1;
  line_t       rd_data0;
  line_t       rd_data1;
  logic        victim_way;
  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_way;
  line_t       hit_data;
  logic        refill_fire;
  logic        lru_we;
  logic        lru_used_way;

  assign req_index = pa_index(req_pa_q);
  assign req_tag   = pa_tag(req_pa_q);

  icache_l1_array u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_index     (req_index),
    .rd_valid     (rd_valid),
    .rd_tag0      (rd_tag0),
    .rd_tag1      (rd_tag1),
    .rd_data0     (rd_data0),
    .rd_data1     (rd_data1),
    .victim_way   (victim_way),
    .wr_en        (refill_fire),
    .wr_way       (victim_way),
    .wr_index     (req_index),
    .wr_tag       (req_tag),
    .wr_data      (i_L2Cache_refillLine_32B),
    .lru_we       (lru_we),
    .lru_index    (req_index),
    .lru_used_way (lru_used_way)
  );

  assign hit0     = rd_valid[0] && (rd_tag0 == req_tag);
  assign hit1     = rd_valid[1] && (rd_tag1 == req_tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = !hit0;
  assign hit_data = hit0 ? rd_data0 : rd_data1;

  // The install happens in the same cycle the refill arrives, so the write
  // strobe and way select follow the L2 drive pulse directly.
  assign refill_fire                  = (state_q == REFILL_WAIT) && i_L2Cache_drive;
  assign o_write_enable               = refill_fire;
  assign o_fifo_buffer_write_enable_2 = refill_fire ? (victim_way ? 2'b10 : 2'b01) : 2'b00;
  assign lru_we                       = ((state_q == LOOKUP) && hit) || refill_fire;
  assign lru_used_way                 = refill_fire ? victim_way : hit_way;

  assign o_fifo2_1_addr_34 = req_pa_q;

  // Drive pulses last one cycle; the matching free is only honoured once the
  // pulse has dropped, so a free coincident with the pulse is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                   <= IDLE;
      req_pa_q                  <= '0;
      o_Itlb_free               <= 1'b1;
      o_driveNext_L2Cache       <= 1'b0;
      o_miss_Addr_to_L2cache_34 <= '0;
      o_L2Cache_free            <= 1'b0;
      o_driveNext_ifu           <= 1'b0;
      o_hit_data_to_ifu_32B     <= '0;
      o_fifo_buffer_data_out    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Itlb_drive) begin
            req_pa_q    <= i_Itlb_PA_34;
            o_Itlb_free <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          o_fifo_buffer_data_out <= hit;
          if (hit) begin
            o_hit_data_to_ifu_32B <= hit_data;
            o_driveNext_ifu       <= 1'b1;
            state_q               <= RESP;
          end else begin
            o_miss_Addr_to_L2cache_34 <= line_addr(req_pa_q);
            o_driveNext_L2Cache       <= 1'b1;
            state_q                   <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (o_driveNext_L2Cache) begin
            o_driveNext_L2Cache <= 1'b0;
          end else if (i_freeNext_L2Cache) begin
            o_L2Cache_free <= 1'b1;
            state_q        <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (i_L2Cache_drive) begin
            o_L2Cache_free        <= 1'b0;
            o_hit_data_to_ifu_32B <= i_L2Cache_refillLine_32B;
            o_driveNext_ifu       <= 1'b1;
            state_q               <= RESP;
          end
        end
        RESP: begin
          if (o_driveNext_ifu) begin
            o_driveNext_ifu <= 1'b0;
          end else if (i_freeNext_ifu) begin
            o_Itlb_free <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          o_Itlb_free <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_l1.sv
// Directed bench for icache_l1: cold misses, same-set fill, hits, LRU eviction,
// handshake corner cases and reset during refill.
module tb_icache_l1;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_Itlb_drive;
  logic [33:0]  i_Itlb_PA_34;
  logic         o_Itlb_free;
  logic         o_driveNext_L2Cache;
  logic [33:0]  o_miss_Addr_to_L2cache_34;
  logic         i_freeNext_L2Cache;
  logic         o_L2Cache_free;
  logic         i_L2Cache_drive;
  logic [255:0] i_L2Cache_refillLine_32B;
  logic         o_driveNext_ifu;
  logic [255:0] o_hit_data_to_ifu_32B;
  logic         i_freeNext_ifu;
  logic         o_write_enable;
  logic [1:0]   o_fifo_buffer_write_enable_2;
  logic [33:0]  o_fifo2_1_addr_34;
  logic         o_fifo_buffer_data_out;

  int cmp_count  = 0;
  int fail_count = 0;

  localparam logic [255:0] LINE_A = 256'hfea5bf5c4ee8c293_ead6fe726109b4f8_6d1c1c1b60d277f3_8f227c1d5e91b527;
  localparam logic [255:0] LINE_B = 256'h1c7e7580_0d3abd0c_c0a08d74_0dc16ff0_c1d55647_421fdea6_47b6810a_637f1a83;
  localparam logic [255:0] LINE_C = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_deadbeefcafef00d;

  always #5 clk = ~clk;

  icache_l1 dut (
    .clk                          (clk),
    .rst                          (rst),
    .i_Itlb_drive                 (i_Itlb_drive),
    .i_Itlb_PA_34                 (i_Itlb_PA_34),
    .o_Itlb_free                  (o_Itlb_free),
    .o_driveNext_L2Cache          (o_driveNext_L2Cache),
    .o_miss_Addr_to_L2cache_34    (o_miss_Addr_to_L2cache_34),
    .i_freeNext_L2Cache           (i_freeNext_L2Cache),
    .o_L2Cache_free               (o_L2Cache_free),
    .i_L2Cache_drive              (i_L2Cache_drive),
    .i_L2Cache_refillLine_32B     (i_L2Cache_refillLine_32B),
    .o_driveNext_ifu              (o_driveNext_ifu),
    .o_hit_data_to_ifu_32B        (o_hit_data_to_ifu_32B),
    .i_freeNext_ifu               (i_freeNext_ifu),
    .o_write_enable               (o_write_enable),
    .o_fifo_buffer_write_enable_2 (o_fifo_buffer_write_enable_2),
    .o_fifo2_1_addr_34            (o_fifo2_1_addr_34),
    .o_fifo_buffer_data_out       (o_fifo_buffer_data_out)
  );

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    cmp_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse a request; returns in the LOOKUP cycle.
  task automatic send(input logic [33:0] pa);
    i_Itlb_drive = 1'b1;
    i_Itlb_PA_34 = pa;
    tick();
    i_Itlb_drive = 1'b0;
  endtask

  task automatic l2_accept(input string tag);
    i_freeNext_L2Cache = 1'b1;
    tick();
    i_freeNext_L2Cache = 1'b0;
    check({tag, "_l2free"}, o_L2Cache_free, 1'b1);
  endtask

  task automatic refill(input string tag, input logic [255:0] line, input logic [1:0] way);
    i_L2Cache_drive          = 1'b1;
    i_L2Cache_refillLine_32B = line;
    #1;
    check({tag, "_we"}, o_write_enable, 1'b1);
    check({tag, "_way"}, o_fifo_buffer_write_enable_2, way);
    tick();
    i_L2Cache_drive = 1'b0;
    check({tag, "_ifu_drive"}, o_driveNext_ifu, 1'b1);
    check({tag, "_ifu_data"}, o_hit_data_to_ifu_32B, line);
    check({tag, "_we_off"}, o_write_enable, 1'b0);
    check({tag, "_l2free_off"}, o_L2Cache_free, 1'b0);
  endtask

  task automatic ifu_release(input string tag, input logic [255:0] line);
    tick();
    check({tag, "_ifu_pulse_end"}, o_driveNext_ifu, 1'b0);
    check({tag, "_ifu_hold"}, o_hit_data_to_ifu_32B, line);
    i_freeNext_ifu = 1'b1;
    tick();
    i_freeNext_ifu = 1'b0;
    check({tag, "_idle"}, o_Itlb_free, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                      = 1'b1;
    i_Itlb_drive             = 1'b0;
    i_Itlb_PA_34             = '0;
    i_freeNext_L2Cache       = 1'b0;
    i_L2Cache_drive          = 1'b0;
    i_L2Cache_refillLine_32B = '0;
    i_freeNext_ifu           = 1'b0;
    repeat (2) tick();

    check("rst_itlb_free", o_Itlb_free, 1'b1);
    check("rst_drive_l2", o_driveNext_L2Cache, 1'b0);
    check("rst_drive_ifu", o_driveNext_ifu, 1'b0);
    check("rst_l2_free", o_L2Cache_free, 1'b0);
    check("rst_ifu_data", o_hit_data_to_ifu_32B, 256'h0);
    check("rst_we", o_write_enable, 1'b0);
    rst = 1'b0;
    tick();

    // Cold miss into way0
    send(34'h234567_abc);
    check("cold_busy", o_Itlb_free, 1'b0);
    check("cold_no_req_yet", o_driveNext_L2Cache, 1'b0);
    tick();
    check("cold_l2_req", o_driveNext_L2Cache, 1'b1);
    check("cold_l2_addr", o_miss_Addr_to_L2cache_34, 34'h234567_aa0);
    check("cold_hitflag", o_fifo_buffer_data_out, 1'b0);
    check("cold_dbg_addr", o_fifo2_1_addr_34, 34'h234567_abc);
    tick();
    check("cold_l2_pulse_end", o_driveNext_L2Cache, 1'b0);
    check("cold_l2_addr_hold", o_miss_Addr_to_L2cache_34, 34'h234567_aa0);
    l2_accept("cold");
    refill("cold", LINE_A, 2'b01);
    ifu_release("cold", LINE_A);

    // Same-set miss into way1; frees coincident with drive pulses are ignored
    send(34'h256789_abc);
    tick();
    check("set2_l2_req", o_driveNext_L2Cache, 1'b1);
    check("set2_l2_addr", o_miss_Addr_to_L2cache_34, 34'h256789_aa0);
    i_freeNext_L2Cache = 1'b1;
    tick();
    i_freeNext_L2Cache = 1'b0;
    check("set2_early_l2free_ignored", o_L2Cache_free, 1'b0);
    l2_accept("set2");
    refill("set2", LINE_B, 2'b10);
    i_freeNext_ifu = 1'b1;
    tick();
    i_freeNext_ifu = 1'b0;
    check("set2_early_ifufree_ignored", o_Itlb_free, 1'b0);
    check("set2_ifu_hold", o_hit_data_to_ifu_32B, LINE_B);
    i_freeNext_ifu = 1'b1;
    tick();
    i_freeNext_ifu = 1'b0;
    check("set2_idle", o_Itlb_free, 1'b1);

    // Hit on way0 (LRU -> way1), then hit on way1 with a different byte offset (LRU -> way0)
    send(34'h234567_abc);
    check("hitA_no_l2_n1", o_driveNext_L2Cache, 1'b0);
    tick();
    check("hitA_ifu_drive", o_driveNext_ifu, 1'b1);
    check("hitA_ifu_data", o_hit_data_to_ifu_32B, LINE_A);
    check("hitA_hitflag", o_fifo_buffer_data_out, 1'b1);
    check("hitA_no_l2", o_driveNext_L2Cache, 1'b0);
    ifu_release("hitA", LINE_A);

    send(34'h256789_ab3);
    tick();
    check("hitB_ifu_drive", o_driveNext_ifu, 1'b1);
    check("hitB_ifu_data", o_hit_data_to_ifu_32B, LINE_B);
    check("hitB_hitflag", o_fifo_buffer_data_out, 1'b1);
    ifu_release("hitB", LINE_B);

    // Third tag evicts way0; a request pulsed during MISS_REQ is dropped
    send(34'h111111_abc);
    tick();
    check("evict_l2_req", o_driveNext_L2Cache, 1'b1);
    check("evict_l2_addr", o_miss_Addr_to_L2cache_34, 34'h111111_aa0);
    tick();
    i_Itlb_drive = 1'b1;
    i_Itlb_PA_34 = 34'h000000_040;
    tick();
    i_Itlb_drive = 1'b0;
    check("drop_busy", o_Itlb_free, 1'b0);
    check("drop_dbg_addr", o_fifo2_1_addr_34, 34'h111111_abc);
    check("drop_l2_addr", o_miss_Addr_to_L2cache_34, 34'h111111_aa0);
    check("drop_no_new_req", o_driveNext_L2Cache, 1'b0);
    l2_accept("evict");
    refill("evict", LINE_C, 2'b01);
    ifu_release("evict", LINE_C);

    // Way1 line survives; evicted tag now misses
    send(34'h256789_abc);
    tick();
    check("survive_ifu_drive", o_driveNext_ifu, 1'b1);
    check("survive_ifu_data", o_hit_data_to_ifu_32B, LINE_B);
    ifu_release("survive", LINE_B);

    send(34'h234567_abc);
    tick();
    check("evicted_miss_req", o_driveNext_L2Cache, 1'b1);
    check("evicted_hitflag", o_fifo_buffer_data_out, 1'b0);
    check("evicted_no_ifu", o_driveNext_ifu, 1'b0);
    tick();
    l2_accept("evicted");

    // Asynchronous reset in REFILL_WAIT
    rst = 1'b1;
    #1;
    check("midrst_itlb_free", o_Itlb_free, 1'b1);
    check("midrst_l2_free", o_L2Cache_free, 1'b0);
    check("midrst_drive_l2", o_driveNext_L2Cache, 1'b0);
    check("midrst_l2_addr", o_miss_Addr_to_L2cache_34, 34'h0);
    tick();
    rst = 1'b0;
    tick();

    send(34'h256789_abc);
    tick();
    check("postrst_miss_req", o_driveNext_L2Cache, 1'b1);
    check("postrst_hitflag", o_fifo_buffer_data_out, 1'b0);
    check("postrst_no_ifu", o_driveNext_ifu, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/icache_l1.md
Name: icache_l1

Overview:
- Level-1 instruction cache between the ITLB (physical-address source), the IFU (line consumer) and the L2 cache (refill source).
- Organisation: 2-way set-associative, 128 sets, 32-byte lines (8 KB data).
- Each physical-address lookup returns a full 32 B line to the IFU on a hit. On a miss it issues a line-aligned request to L2, installs the refill line, then forwards that line to the IFU.
- All handshakes are single-cycle drive/free pulses, synchronous to one clock.

Parameters:
- PA_W, 34, physical address width
- LINE_W, 256, line width in bits (32 B)
- SETS, 128, number of sets; index = PA[11:5]
- TAG_W, 22, tag width = PA[33:12]

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_Itlb_drive  in  1  one-cycle request pulse; i_Itlb_PA_34 valid in the same cycle
- i_Itlb_PA_34  in  34  physical fetch address
- o_Itlb_free  out  1  high when the block is in IDLE and can accept a request
- o_driveNext_L2Cache  out  1  one-cycle miss-request pulse to L2
- o_miss_Addr_to_L2cache_34  out  34  line-aligned miss address {PA[33:5],5'b0}, held until refill
- i_freeNext_L2Cache  in  1  L2 accepted the miss request (pulse)
- o_L2Cache_free  out  1  high while waiting for refill data
- i_L2Cache_drive  in  1  refill-valid pulse
- i_L2Cache_refillLine_32B  in  256  refill line
- o_driveNext_ifu  out  1  one-cycle data-valid pulse to the IFU
- o_hit_data_to_ifu_32B  out  256  line to the IFU, held until i_freeNext_ifu
- i_freeNext_ifu  in  1  IFU consumed the line (pulse)
- o_write_enable  out  1  one-cycle array write strobe during refill install
- o_fifo_buffer_write_enable_2  out  2  one-hot way being written (valid with o_write_enable), else 0
- o_fifo2_1_addr_34  out  34  last accepted request PA (debug)
- o_fifo_buffer_data_out  out  1  hit flag of the last lookup (debug)

Behaviour:
- Storage:
  - per set: 2 ways of {valid, tag[21:0], data[255:0]}, plus 1 LRU bit giving the way to replace next.
  - Register arrays; combinational read.
- Reset (asynchronous):
  - all valid bits and LRU bits cleared; state = IDLE.
  - all outputs 0 except o_Itlb_free = 1.
  - Reset mid-operation aborts any transaction with no pending pulses.
- States and transitions:
  - IDLE: o_Itlb_free = 1. On i_Itlb_drive, capture PA into req_pa and go to LOOKUP.
  - LOOKUP (1 cycle): hit = valid & (tag == req_pa[33:12]) for either way; record the hit flag.
    - Hit: latch the way's data into the output register, set LRU to the other way, go to RESP.
    - Miss: go to MISS_REQ.
  - MISS_REQ: o_driveNext_L2Cache pulses in the first cycle only; address held. Stay until i_freeNext_L2Cache, then go to REFILL_WAIT.
  - REFILL_WAIT: o_L2Cache_free = 1. On i_L2Cache_drive:
    - victim = first invalid way (way0 preferred), else the LRU way.
    - write tag, valid and data; pulse o_write_enable with the one-hot way.
    - set LRU to the other way; latch the refill line into the output register; go to RESP.
  - RESP: o_driveNext_ifu pulses in the first cycle only; data held. Stay until i_freeNext_ifu, then go to IDLE.
- Latency:
  - i_Itlb_drive in cycle N → LOOKUP in N+1.
  - Hit: o_driveNext_ifu in N+2.
  - Miss: o_driveNext_L2Cache in N+2.
  - i_L2Cache_drive in cycle M → o_driveNext_ifu in M+1.
- Ignored inputs:
  - Drive/free pulses arriving outside their consuming state are ignored.
  - i_Itlb_drive while not IDLE is dropped; the source must wait for o_Itlb_free.
- A free pulse arriving in the same cycle as the matching drive pulse is ignored. Free is honoured only from the cycle after the drive pulse.
- Byte offset PA[4:0] is ignored; the whole line is always returned.

Decomposition:
- Shared package: PA_W, LINE_W, SETS, TAG_W; state enum {IDLE, LOOKUP, MISS_REQ, REFILL_WAIT, RESP}; index/tag field-slice constants.
- One sub-module, icache_l1_array: tag/valid/data/LRU storage with read port, write port and victim select.
- The control FSM stays in the top module.

Test Plan:
- Cold miss: after reset, drive PA 34'h234567_abc → o_driveNext_L2Cache pulse with addr 34'h234567_aa0; o_Itlb_free = 0.
- Refill: i_freeNext_L2Cache, then i_L2Cache_drive with 256'hfea5bf5c4ee8c293_ead6fe726109b4f8_6d1c1c1b60d277f3_8f227c1d5e91b527 →
  - o_write_enable with way = 2'b01;
  - o_driveNext_ifu next cycle, data equal to the refill line;
  - i_freeNext_ifu → IDLE.
- Same-set second miss: drive 34'h256789_abc (same index 0x55) → miss. Refill with 256'h1c7e7580_0d3abd0c_c0a08d74_0dc16ff0_c1d55647_421fdea6_47b6810a_637f1a83 → written to way 2'b10, returned to the IFU.
- Hit: drive 34'h234567_abc → no L2 request; o_driveNext_ifu two cycles after drive with the first line; debug hit flag = 1.
- LRU eviction: third tag 34'h111111_abc misses and replaces way0 (LRU after the previous hit on way0 points to way1; accessing 256789 first flips it). Check the evicted tag then misses.
- Robustness:
  - i_Itlb_drive pulsed in MISS_REQ is ignored;
  - asserting rst in REFILL_WAIT → o_Itlb_free = 1 and the previously filled address misses.
